accumulator_feeder: RTL and testbench

Upstream stage of the parallel accumulator. Accepts operands from a producer over a valid/ready handshake and buffers them in a small synchronous FIFO. On start, drives exactly BURST_LEN operands onto the accumulator's 32-bit load input, one per cycle, inserting zero bubbles when starved. It then flushes the accumulator pipeline with zeros and pulses done, at which point the accumulator result is final.

---
 rtl/acc_pkg.sv | 14 +
 rtl/accumulator_feeder_if.sv | 29 ++
 rtl/accumulator_feeder_fifo.sv | 63 ++++++
 rtl/accumulator_feeder.sv | 122 ++++++++++++
 tb/tb_accumulator_feeder.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator and its operand feeder.
package acc_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned BURST_LEN_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/accumulator_feeder_if.sv
// Operand path: producer handshake in, accumulator load bus out.
interface accumulator_feeder_if;
    import acc_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] load;
    logic              load_valid;

    // Testbench / surrounding logic side
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  load,
        input  load_valid
    );

    // Feeder side
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output load,
        output load_valid
    );

endinterface

// File: rtl/accumulator_feeder_fifo.sv
// Synchronous operand FIFO; extra pointer bit distinguishes full from empty.
module accumulator_feeder_fifo #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rd_data_c,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              push_ok, pop_ok;

    // Gate requests on current flags (no full-bypass) and derive next flags
    always_comb begin
        push_ok  = push_i && !full_q;
        pop_ok   = pop_i && !empty_q;
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    // Pointer and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_c = mem_q[rd_ptr_q[AW-1:0]];
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule

// File: rtl/accumulator_feeder.sv
// Feeds exactly BURST_LEN buffered operands to the accumulator, then flushes it with zeros.
module accumulator_feeder
    import acc_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned BURST_LEN    = BURST_LEN_DEF,
    parameter int unsigned FLUSH_CYCLES = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    accumulator_feeder_if.slave                bus,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(BURST_LEN+1)-1:0]     count
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
    localparam int unsigned FL_W  = $clog2(FLUSH_CYCLES + 1);

    feeder_state_e     state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [FL_W-1:0]   flush_q, flush_d;
    logic [DATA_W-1:0] load_q, load_d;
    logic              load_valid_q, load_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pop_c;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    accumulator_feeder_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (bus.in_valid),
        .wr_data_i (bus.in_data),
        .pop_i     (pop_c),
        .rd_data_c (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Next state, counters and registered output values
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        flush_d = flush_q;
        pop_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    count_d = '0;
                end
            end
            RUN: begin
                if (!fifo_empty && (count_q < CNT_W'(BURST_LEN))) begin
                    pop_c   = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(BURST_LEN - 1)) begin
                        state_d = FLUSH;
                        flush_d = '0;
                    end
                end
            end
            FLUSH: begin
                // First FLUSH cycle still presents the last operand on load,
                // so one extra cycle yields FLUSH_CYCLES zero cycles on the bus.
                if (flush_q == FL_W'(FLUSH_CYCLES)) begin
                    state_d = DONE;
                end else begin
                    flush_d = flush_q + FL_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        load_d       = pop_c ? fifo_head : '0;
        load_valid_d = pop_c;
        busy_d       = (state_d == RUN) || (state_d == FLUSH);
        done_d       = (state_d == DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            flush_q      <= '0;
            load_q       <= '0;
            load_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            flush_q      <= flush_d;
            load_q       <= load_d;
            load_valid_q <= load_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.in_ready   = !fifo_full;
    assign bus.load       = load_q;
    assign bus.load_valid = load_valid_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign count          = count_q;

endmodule

// File: tb/tb_accumulator_feeder.sv
// Scoreboard bench: a short-burst instance for directed cases, a full-length one for random traffic.
module tb_accumulator_feeder;
    import acc_pkg::*;

    localparam int unsigned BL_S  = 4;
    localparam int unsigned BL_L  = 1024;
    localparam int unsigned FLUSH = 8;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst_s, rst_l, start_s, start_l;
    logic busy_s, busy_l, done_s_o, done_l_o;
    logic [$clog2(BL_S+1)-1:0] cnt_s;
    logic [$clog2(BL_L+1)-1:0] cnt_l;

    accumulator_feeder_if if_s ();
    accumulator_feeder_if if_l ();

    accumulator_feeder #(.FIFO_DEPTH(DEPTH), .BURST_LEN(BL_S), .FLUSH_CYCLES(FLUSH)) dut_s (
        .clk(clk), .reset(rst_s), .start(start_s), .bus(if_s),
        .busy(busy_s), .done(done_s_o), .count(cnt_s)
    );

    accumulator_feeder #(.FIFO_DEPTH(DEPTH), .BURST_LEN(BL_L), .FLUSH_CYCLES(FLUSH)) dut_l (
        .clk(clk), .reset(rst_l), .start(start_l), .bus(if_l),
        .busy(busy_l), .done(done_l_o), .count(cnt_l)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: operands leave in push order, bursts are exactly BURST_LEN long,
    // done arrives FLUSH+1 cycles after the last operand, idle load bus is zero.
    logic [31:0] exp_s[$];
    logic [31:0] exp_l[$];
    int          cyc_s = 0, cyc_l = 0;
    int          lv_s = 0, lv_l = 0;
    int          last_s = 0, last_l = 0;
    int          done_s = 0, done_l = 0;
    int          pushed_l = 0;
    longint      sum_l = 0, ref_sum_l = 0;

    // Short-burst monitor
    always @(negedge clk) begin
        cyc_s++;
        if (if_s.load_valid) begin
            if (exp_s.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL load_unexpected_s: got 0x%0h, expected no operand", if_s.load);
            end else begin
                check("load_order_s", 64'(if_s.load), 64'(exp_s.pop_front()));
            end
            lv_s++;
            last_s = cyc_s;
        end else begin
            check("load_zero_s", 64'(if_s.load), 64'd0);
        end
        if (done_s_o) begin
            done_s++;
            check("burst_len_s", 64'(lv_s), 64'(BL_S));
            check("flush_gap_s", 64'(cyc_s - last_s), 64'(FLUSH + 1));
            check("done_count_s", 64'(cnt_s), 64'(BL_S));
            check("done_busy_s", 64'(busy_s), 64'd0);
            lv_s = 0;
        end
        if (rst_s) begin
            exp_s.delete();
            lv_s = 0;
        end else if (if_s.in_valid && if_s.in_ready) begin
            exp_s.push_back(if_s.in_data);
        end
    end

    // Full-length monitor
    always @(negedge clk) begin
        cyc_l++;
        if (if_l.load_valid) begin
            if (exp_l.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL load_unexpected_l: got 0x%0h, expected no operand", if_l.load);
            end else begin
                check("load_order_l", 64'(if_l.load), 64'(exp_l.pop_front()));
            end
            lv_l++;
            last_l = cyc_l;
        end else begin
            check("load_zero_l", 64'(if_l.load), 64'd0);
        end
        sum_l += longint'(if_l.load);
        if (done_l_o) begin
            done_l++;
            check("burst_len_l", 64'(lv_l), 64'(BL_L));
            check("sum_l", 64'(sum_l), 64'(ref_sum_l));
            check("flush_gap_l", 64'(cyc_l - last_l), 64'(FLUSH + 1));
            check("done_count_l", 64'(cnt_l), 64'(BL_L));
        end
        if (rst_l) begin
            exp_l.delete();
            lv_l = 0;
            pushed_l = 0;
            sum_l = 0;
            ref_sum_l = 0;
        end else if (if_l.in_valid && if_l.in_ready) begin
            exp_l.push_back(if_l.in_data);
            if (pushed_l < int'(BL_L)) ref_sum_l += longint'(if_l.in_data);
            pushed_l++;
        end
    end

    task automatic wait_done_s(input int budget);
        int target;
        int c;
        target = done_s + 1;
        c = 0;
        while (done_s < target && c < budget) begin
            step();
            c++;
        end
        check("done_s_seen", 64'(done_s >= target), 64'd1);
    endtask

    task automatic push_s(input logic [31:0] d);
        if_s.in_valid = 1'b1;
        if_s.in_data  = d;
        step();
        if_s.in_valid = 1'b0;
    endtask

    task automatic pulse_start_s();
        start_s = 1'b1;
        step();
        start_s = 1'b0;
    endtask

    initial begin
        int dcount;
        rst_s = 1'b1; rst_l = 1'b1;
        start_s = 1'b0; start_l = 1'b0;
        if_s.in_valid = 1'b1; if_s.in_data = 32'hAAAA;
        if_l.in_valid = 1'b0; if_l.in_data = '0;

        // Reset held with in_valid high: nothing may be captured
        step(); step();
        rst_s = 1'b0; rst_l = 1'b0;
        if_s.in_valid = 1'b0;
        check("rst_load", 64'(if_s.load), 64'd0);
        check("rst_load_valid", 64'(if_s.load_valid), 64'd0);
        check("rst_in_ready", 64'(if_s.in_ready), 64'd1);
        check("rst_count", 64'(cnt_s), 64'd0);
        check("rst_busy", 64'(busy_s), 64'd0);
        check("rst_done", 64'(done_s_o), 64'd0);

        // Starvation: bubbles until the late push reaches load two edges later
        pulse_start_s();
        check("starve_busy", 64'(busy_s), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("starve_bubble", 64'(if_s.load_valid), 64'd0);
            check("starve_count", 64'(cnt_s), 64'd0);
        end
        push_s(32'h0005);
        check("starve_latency", 64'(if_s.load_valid), 64'd0);
        step();
        check("starve_load", 64'(if_s.load), 64'h5);
        check("starve_count1", 64'(cnt_s), 64'd1);
        push_s(32'h0006);
        push_s(32'h0007);
        push_s(32'h0008);
        wait_done_s(40);
        step();

        // Prefetch then burst: operands back to back, 8 zero cycles, single done
        for (int i = 1; i <= 4; i++) push_s(32'(i));
        pulse_start_s();
        for (int i = 1; i <= 4; i++) begin
            step();
            check("pre_load", 64'(if_s.load), 64'(i));
            check("pre_valid", 64'(if_s.load_valid), 64'd1);
        end
        for (int k = 0; k < int'(FLUSH); k++) begin
            step();
            check("flush_load", 64'(if_s.load), 64'd0);
            check("flush_done", 64'(done_s_o), 64'd0);
        end
        step();
        check("done_pulse", 64'(done_s_o), 64'd1);
        check("done_cnt", 64'(cnt_s), 64'd4);
        step();
        check("done_single", 64'(done_s_o), 64'd0);
        check("count_hold", 64'(cnt_s), 64'd4);

        // Full FIFO: 16 accepted, the 17th refused, ready returns after first pop
        for (int i = 0; i < int'(DEPTH); i++) push_s(32'h100 + 32'(i));
        check("full_ready", 64'(if_s.in_ready), 64'd0);
        if_s.in_valid = 1'b1; if_s.in_data = 32'h99;
        step();
        check("full_refuse", 64'(if_s.in_ready), 64'd0);
        if_s.in_valid = 1'b0;
        pulse_start_s();
        check("full_ready_run", 64'(if_s.in_ready), 64'd0);
        step();
        check("full_first_pop", 64'(if_s.load), 64'h100);
        check("full_ready_back", 64'(if_s.in_ready), 64'd1);
        wait_done_s(40);
        step();

        // Reset mid-burst after two operands
        dcount = done_s;
        pulse_start_s();
        step();
        check("mid_op1", 64'(if_s.load), 64'h104);
        step();
        check("mid_op2", 64'(if_s.load), 64'h105);
        rst_s = 1'b1;
        step();
        rst_s = 1'b0;
        check("mid_load_valid", 64'(if_s.load_valid), 64'd0);
        check("mid_count", 64'(cnt_s), 64'd0);
        check("mid_busy", 64'(busy_s), 64'd0);
        check("mid_ready", 64'(if_s.in_ready), 64'd1);
        pulse_start_s();
        for (int i = 0; i < 12; i++) begin
            step();
            check("mid_empty", 64'(if_s.load_valid), 64'd0);
        end
        check("mid_no_done", 64'(done_s), 64'(dcount));
        rst_s = 1'b1;
        step();
        rst_s = 1'b0;

        // Random full-length burst
        start_l = 1'b1;
        step();
        start_l = 1'b0;
        for (int c = 0; c < 8000 && done_l == 0; c++) begin
            if_l.in_valid = ($urandom_range(3) != 0);
            if_l.in_data  = 32'($urandom_range(65535));
            step();
        end
        if_l.in_valid = 1'b0;
        check("done_l_seen", 64'(done_l), 64'd1);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
